dmem_lsu_port: RTL

- Parametrised single-port data memory for the single-cycle and pipelined cores.
- Supports sub-word load/store (byte/half/word/dword), sign/zero extension and byte-lane writes.
- Uses a valid/ready request channel and a fixed-latency response channel.
- Flags misaligned or out-of-range accesses and optionally clears memory after reset via an init state machine.

---
 rtl/dmem_lsu_pkg.sv | 40 ++++
 rtl/dmem_lsu_port_rsp_pipe.sv | 44 ++++
 rtl/dmem_lsu_port.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the data-memory load/store port.
// Lane masks and extension work at 64-bit width; callers truncate.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  function automatic logic [7:0] lane_mask(
    input size_e      size,
    input logic [2:0] boff
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (1'b1)
      size == SZ_B: m = 8'h01;
      size == SZ_H: m = 8'h03;
      size == SZ_W: m = 8'h0f;
      default:      m = 8'hff;
    endcase
    return m << boff;
  endfunction

  function automatic logic [63:0] extend(
    input logic [63:0] data,
    input size_e       size,
    input logic        uns
  );
    logic [63:0] r;
    r = data;
    unique case (1'b1)
      size == SZ_B: r = {{56{~uns & data[7]}}, data[7:0]};
      size == SZ_H: r = {{48{~uns & data[15]}}, data[15:0]};
      size == SZ_W: r = {{32{~uns & data[31]}}, data[31:0]};
      default:      r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_port_rsp_pipe.sv
// Fixed-latency response shift register; each stage holds valid/err/data.
// Err and data are forced to zero in invalid stages so outputs idle at 0.
module dmem_rsp_pipe #(
  parameter int LATENCY = 1,
  parameter int DWIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DWIDTH-1:0] out_data
);

  logic              v [LATENCY];
  logic              e [LATENCY];
  logic [DWIDTH-1:0] d [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        v[i] <= 1'b0;
        e[i] <= 1'b0;
        d[i] <= '0;
      end
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_err;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LATENCY-1];
  assign out_err   = e[LATENCY-1];
  assign out_data  = d[LATENCY-1];

endmodule

// File: rtl/dmem_lsu_port.sv
// Single-port data memory with sub-word load/store and error flagging.
// Optional post-reset clear sweep holds off requests for DEPTH cycles.
module dmem_lsu_port
  import dmem_lsu_pkg::*;
#(
  parameter int    DWIDTH         = 32,
  parameter int    AWIDTH         = 32,
  parameter int    DEPTH          = 64,
  parameter int    LATENCY        = 1,
  parameter bit    CLEAR_ON_RESET = 1'b0,
  parameter string MIF_HEX        = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int NB   = DWIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SHW  = OFFW + 3;
  localparam int WW   = AWIDTH - OFFW;
  localparam int CW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WW-1:0] DEPTH_V = WW'(DEPTH);
  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);

  state_e          state;
  state_e          state_nxt;
  logic [CW-1:0]   clr_cnt;
  logic            clr_we;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [WW-1:0]     widx;
  logic [OFFW-1:0]   boff;
  logic [OFFW-1:0]   amask;
  logic [CW-1:0]     wsel;
  logic [SHW-1:0]    sh;
  size_e             size;
  logic              err;
  logic              acc;
  logic              st_we;
  logic [NB-1:0]     bmask;
  logic [DWIDTH-1:0] wsh;
  logic [DWIDTH-1:0] rword;
  logic [DWIDTH-1:0] rsh;
  logic [DWIDTH-1:0] ldata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    unique case (state)
      ST_INIT: begin
        clr_we = 1'b1;
        if (clr_cnt == LAST) state_nxt = ST_RUN;
      end
      ST_RUN:  req_ready = 1'b1;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign size  = size_e'(req_size);
  assign widx  = req_addr[AWIDTH-1:OFFW];
  assign boff  = req_addr[OFFW-1:0];
  assign wsel  = widx[CW-1:0];
  assign sh    = {boff, 3'b000};
  assign amask = OFFW'((32'd1 << req_size) - 32'd1);

  assign err = (|(boff & amask))
             | (widx >= DEPTH_V)
             | ((DWIDTH == 32) && (size == SZ_D));

  assign acc   = req_valid & req_ready;
  assign st_we = acc & req_we & ~err;
  assign bmask = NB'(lane_mask(size, 3'(boff)));
  assign wsh   = req_wdata << sh;

  // Read is combinational, so a load right after a store sees new data.
  assign rword = mem[wsel];
  assign rsh   = rword >> sh;
  assign ldata = (req_we | err) ? '0
               : DWIDTH'(extend(64'(rsh), size, req_unsigned));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (st_we) begin
      for (int i = 0; i < NB; i++) begin
        if (bmask[i]) mem[wsel][8*i +: 8] <= wsh[8*i +: 8];
      end
    end
  end

  dmem_rsp_pipe #(
    .LATENCY(LATENCY),
    .DWIDTH (DWIDTH)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (acc),
    .in_err   (err),
    .in_data  (ldata),
    .out_valid(rsp_valid),
    .out_err  (rsp_err),
    .out_data (rsp_rdata)
  );

endmodule
